// File: rtl/axistream_snooper_mux_pkg.sv
// Shared definitions for the multi-channel AXI-Stream snooper.
//   state_e     : capture FSM states (idle / capture / done)
//   clog2_min1  : $clog2 clamped to at least 1, for index widths of 1-entry arrays
//   popcount    : number of set bits in a byte-enable vector (up to MaxKeepW bits)
package axistream_snooper_mux_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2
  } state_e;

  // Widest TKEEP the popcount helper handles (1024-bit TDATA).
  localparam int unsigned MaxKeepW = 128;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned popcount(input logic [MaxKeepW-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MaxKeepW; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/axistream_snooper_mux_if.sv
// Bundle of the snooped AXI-Stream links and the packet-memory write port.
//   snoop_*      : N_CH observed streams, channel i at slice i of each vector
//   ch_enable    : per-channel capture enable
//   mem_ready    : packet memory buffer free
//   wr_*         : packet memory write port
//   done/byte_len/src_ch/truncated : per-packet completion report
//   drop_cnt     : packets dropped across all channels
// Modports: slave = snooper side, master = environment side.
interface axistream_snooper_mux_if
  import axistream_snooper_mux_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 16
);
  localparam int unsigned KeepW = DATA_WIDTH / 8;
  localparam int unsigned ChW   = clog2_min1(N_CH);
  localparam int unsigned LenW  = ADDR_WIDTH + $clog2(KeepW) + 1;

  logic [N_CH*DATA_WIDTH-1:0] snoop_TDATA;
  logic [N_CH*KeepW-1:0]      snoop_TKEEP;
  logic [N_CH-1:0]            snoop_TVALID;
  logic [N_CH-1:0]            snoop_TREADY;
  logic [N_CH-1:0]            snoop_TLAST;
  logic [N_CH-1:0]            ch_enable;
  logic                       mem_ready;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       wr_en;
  logic                       done;
  logic [LenW-1:0]            byte_len;
  logic [ChW-1:0]             src_ch;
  logic                       truncated;
  logic [CNT_WIDTH-1:0]       drop_cnt;

  modport slave (
    input  snoop_TDATA, snoop_TKEEP, snoop_TVALID, snoop_TREADY, snoop_TLAST,
    input  ch_enable, mem_ready,
    output wr_addr, wr_data, wr_en, done, byte_len, src_ch, truncated, drop_cnt
  );

  modport master (
    output snoop_TDATA, snoop_TKEEP, snoop_TVALID, snoop_TREADY, snoop_TLAST,
    output ch_enable, mem_ready,
    input  wr_addr, wr_data, wr_en, done, byte_len, src_ch, truncated, drop_cnt
  );

endinterface

// File: rtl/axistream_snooper_mux_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   gnt_o : one-hot grant of the first request at/after ptr_i (wrapping)
//   idx_o : index of the granted request
//   any_o : at least one request present
module axistream_snooper_mux_rr_arbiter
  import axistream_snooper_mux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned IdxW = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [31:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      pos = (32'(ptr_i) + off) % N_CH;
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/axistream_snooper_mux.sv
// Passive N-channel AXI-Stream snooper feeding a packet memory.
// Picks one channel at a packet boundary (round robin), copies that whole packet into the
// memory starting at word 0, then reports byte length, source channel and truncation with a
// one-cycle done pulse. Start beats that cannot be captured are counted as drops.
// Ports:
//   axi_aclk    : clock
//   axi_aresetn : asynchronous active-low reset
//   bus         : axistream_snooper_mux_if.slave (snooped streams in, write port/report out)
// Build option: define SNOOPER_DROP_CNT_EN to build the drop counter; otherwise drop_cnt is 0.
module axistream_snooper_mux
  import axistream_snooper_mux_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                    axi_aclk,
  input logic                    axi_aresetn,
  axistream_snooper_mux_if.slave bus
);

  localparam int unsigned KeepW = DATA_WIDTH / 8;
  localparam int unsigned ChW   = clog2_min1(N_CH);
  localparam int unsigned LenW  = ADDR_WIDTH + $clog2(KeepW) + 1;
  localparam logic [ADDR_WIDTH:0] CapWords = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [LenW-1:0]     CapBytes = LenW'(CapWords) * LenW'(KeepW);

  state_e state_q, state_d;

  logic [N_CH-1:0] beat, start, cand;
  logic [N_CH-1:0] in_pkt_q, in_pkt_d;

  logic [N_CH-1:0] arb_gnt;
  logic [ChW-1:0]  arb_idx;
  logic            arb_any;
  logic            grant_fire;

  logic [ChW-1:0]  rr_q, rr_d;
  logic [ChW-1:0]  src_ch_q, src_ch_d;
  logic [N_CH-1:0] src_oh_q, src_oh_d;
  // TLAST already taken; the next cycle closes the packet.
  logic            last_q, last_d;
  logic [ADDR_WIDTH:0] wcnt_q, wcnt_d;
  logic [ADDR_WIDTH:0] base_cnt;
  logic            take;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [LenW-1:0]       byte_len_q, byte_len_d;
  logic                  trunc_q, trunc_d;

  logic [N_CH-1:0]       sel_oh;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [KeepW-1:0]      keep_sel;
  logic                  last_sel;
  logic                  beat_sel;

  // Packet boundary tracking runs on every channel, captured or not.
  always_comb begin
    beat     = bus.snoop_TVALID & bus.snoop_TREADY;
    start    = beat & ~in_pkt_q;
    cand     = start & bus.ch_enable;
    in_pkt_d = in_pkt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (beat[i]) begin
        in_pkt_d[i] = ~bus.snoop_TLAST[i];
      end
    end
  end

  axistream_snooper_mux_rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req_i (cand),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign grant_fire = (state_q == StIdle) && bus.mem_ready && arb_any;

  // One-hot AND-OR mux: the new grant while idle, otherwise the channel being captured.
  always_comb begin
    sel_oh   = (state_q == StIdle) ? arb_gnt : src_oh_q;
    data_sel = '0;
    keep_sel = '0;
    last_sel = 1'b0;
    beat_sel = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel_oh[i]) begin
        data_sel |= bus.snoop_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        keep_sel |= bus.snoop_TKEEP[i*KeepW +: KeepW];
        last_sel |= bus.snoop_TLAST[i];
        beat_sel |= beat[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    src_ch_d   = src_ch_q;
    src_oh_d   = src_oh_q;
    last_d     = last_q;
    wcnt_d     = wcnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    byte_len_d = byte_len_q;
    trunc_d    = trunc_q;
    take       = 1'b0;
    base_cnt   = wcnt_q;

    unique case (state_q)
      StIdle: begin
        if (grant_fire) begin
          state_d  = StCapture;
          rr_d     = ChW'((32'(arb_idx) + 32'd1) % N_CH);
          src_ch_d = arb_idx;
          src_oh_d = arb_gnt;
          trunc_d  = 1'b0;
          base_cnt = '0;
          take     = 1'b1;
        end
      end
      StCapture: begin
        if (last_q) begin
          state_d = StDone;
          last_d  = 1'b0;
        end else if (beat_sel) begin
          take = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (take) begin
      last_d = last_sel;
      if (base_cnt < CapWords) begin
        wr_en_d    = 1'b1;
        wr_addr_d  = base_cnt[ADDR_WIDTH-1:0];
        wr_data_d  = data_sel;
        wcnt_d     = base_cnt + 1'b1;
        byte_len_d = LenW'(base_cnt) * LenW'(KeepW)
                   + LenW'(popcount(MaxKeepW'(keep_sel)));
      end else begin
        // Memory full: drop the beat, keep address parked, report full capacity.
        wcnt_d     = base_cnt;
        trunc_d    = 1'b1;
        byte_len_d = CapBytes;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= StIdle;
      in_pkt_q   <= '0;
      rr_q       <= '0;
      src_ch_q   <= '0;
      src_oh_q   <= '0;
      last_q     <= 1'b0;
      wcnt_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      byte_len_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_pkt_q   <= in_pkt_d;
      rr_q       <= rr_d;
      src_ch_q   <= src_ch_d;
      src_oh_q   <= src_oh_d;
      last_q     <= last_d;
      wcnt_q     <= wcnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      byte_len_q <= byte_len_d;
      trunc_q    <= trunc_d;
    end
  end

`ifdef SNOOPER_DROP_CNT_EN
  // At most one drop per cycle is counted even if several channels lose in the same cycle.
  logic                 drop;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  assign drop = |(cand & ~(grant_fire ? arb_gnt : '0));

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = {CNT_WIDTH{1'b0}};
`endif

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.done      = (state_q == StDone);
  assign bus.byte_len  = byte_len_q;
  assign bus.src_ch    = src_ch_q;
  assign bus.truncated = trunc_q;

endmodule

// File: tb/tb_axistream_snooper_mux.sv
module tb_axistream_snooper_mux;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int AW  = 3;
  localparam int CW  = 16;
  localparam int KW  = DW / 8;
  localparam int CAP = 1 << AW;

  typedef struct {
    int          cyc;
    int          addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int cyc;
    int blen;
    int src;
    int trunc;
  } dn_t;

  logic clk;
  logic rst_n;
  int   cyc;

  axistream_snooper_mux_if #(
    .N_CH       (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) sif ();

  axistream_snooper_mux #(
    .N_CH       (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .bus         (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  wr_t wq[$];
  dn_t dq[$];

  // Reference model state: whole-packet view of the capture engine.
  bit             m_in_pkt[N];
  int             m_rr, m_cap, m_words, m_avail, m_drop;
  logic [N-1:0]   en;
  logic           mr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_in_pkt[i] = 1'b0;
    m_rr = 0; m_cap = -1; m_words = 0; m_avail = 0; m_drop = 0;
    wq.delete();
    dq.delete();
  endtask

  // Drive one cycle of stimulus and advance the reference model by that cycle.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] r, input logic [N-1:0] l,
                      input int kc);
    logic [DW-1:0] ds[N];
    int            kcs[N];
    logic [N-1:0]  cand;
    int            g;
    wr_t           w;
    dn_t           d;
    for (int i = 0; i < N; i++) begin
      ds[i]  = {$urandom, $urandom};
      kcs[i] = (kc > 0) ? kc : int'($urandom_range(KW, 1));
      sif.snoop_TDATA[i*DW +: DW] = ds[i];
      sif.snoop_TKEEP[i*KW +: KW] = l[i] ? KW'((64'd1 << kcs[i]) - 64'd1) : {KW{1'b1}};
    end
    sif.snoop_TVALID = v;
    sif.snoop_TREADY = r;
    sif.snoop_TLAST  = l;
    sif.ch_enable    = en;
    sif.mem_ready    = mr;

    cand = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i] && r[i] && !m_in_pkt[i] && en[i]) cand[i] = 1'b1;
    end
    g = -1;
    if (m_cap < 0 && cyc >= m_avail && mr && cand != '0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (g < 0 && cand[j]) g = j;
      end
      m_rr = (g + 1) % N; m_cap = g; m_words = 0; m_avail = 1 << 30;
    end
    for (int i = 0; i < N; i++) begin
      if (cand[i] && i != g) begin
        if (m_drop < (1 << CW) - 1) m_drop++;
        break;
      end
    end
    if (m_cap >= 0 && v[m_cap] && r[m_cap]) begin
      if (m_words < CAP) begin
        w.cyc = cyc + 1; w.addr = m_words; w.data = ds[m_cap];
        wq.push_back(w);
      end
      m_words++;
      if (l[m_cap]) begin
        d.cyc   = cyc + 2;
        d.src   = m_cap;
        d.trunc = (m_words > CAP) ? 1 : 0;
        d.blen  = (m_words > CAP) ? CAP * KW : (m_words - 1) * KW + kcs[m_cap];
        dq.push_back(d);
        m_avail = cyc + 3;
        m_cap   = -1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] && r[i]) m_in_pkt[i] = !l[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, 1);
  endtask

  task automatic pkt(input int ch, input int len, input int kc);
    logic [N-1:0] m;
    m = N'(1) << ch;
    for (int b = 0; b < len; b++) step(m, m, (b == len - 1) ? m : '0, kc);
  endtask

  task automatic check_drop(input string tag);
`ifdef SNOOPER_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 64'(sif.drop_cnt), 64'(m_drop));
`else
    check({tag, "_drop_cnt"}, 64'(sif.drop_cnt), 64'd0);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, 64'(sif.wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(sif.wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(sif.wr_data), 64'd0);
    check({tag, "_done"}, 64'(sif.done), 64'd0);
    check({tag, "_byte_len"}, 64'(sif.byte_len), 64'd0);
    check({tag, "_src_ch"}, 64'(sif.src_ch), 64'd0);
    check({tag, "_truncated"}, 64'(sif.truncated), 64'd0);
    check({tag, "_drop_cnt"}, 64'(sif.drop_cnt), 64'd0);
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard queues.
  wr_t ew;
  dn_t ed;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.wr_en === 1'b1) begin
        if (wq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_unexpected: wr_en=1 addr=%0d at cycle %0d, required no write",
                   sif.wr_addr, cyc);
        end else begin
          ew = wq.pop_front();
          check("wr_cycle", 64'(cyc), 64'(ew.cyc));
          check("wr_addr", 64'(sif.wr_addr), 64'(ew.addr));
          check("wr_data", sif.wr_data, ew.data);
        end
      end
      if (sif.done === 1'b1) begin
        if (dq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_unexpected: done=1 at cycle %0d, required no done", cyc);
        end else begin
          ed = dq.pop_front();
          check("done_cycle", 64'(cyc), 64'(ed.cyc));
          check("byte_len", 64'(sif.byte_len), 64'(ed.blen));
          check("src_ch", 64'(sif.src_ch), 64'(ed.src));
          check("truncated", 64'(sif.truncated), 64'(ed.trunc));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en = '1;
    mr = 1'b1;
    sif.snoop_TDATA = '0; sif.snoop_TKEEP = '0; sif.snoop_TVALID = '0;
    sif.snoop_TREADY = '0; sif.snoop_TLAST = '0; sif.ch_enable = '1; sif.mem_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four-beat packet on ch0, 4 bytes valid in last beat.
    pkt(0, 4, 4);
    idle(4);
    check_drop("t1");

    // Simultaneous single-beat starts on ch1/ch2, twice: round robin alternates.
    step(4'b0110, 4'b0110, 4'b0110, 3);
    idle(4);
    step(4'b0110, 4'b0110, 4'b0110, 5);
    idle(4);
    check_drop("t2");

    // Memory busy at the start beat: whole packet is dropped even after mem_ready rises.
    mr = 1'b0;
    step(4'b0001, 4'b0001, 4'b0000, 8);
    mr = 1'b1;
    step(4'b0001, 4'b0001, 4'b0000, 8);
    step(4'b0001, 4'b0001, 4'b0001, 8);
    idle(4);
    check_drop("t3");

    // Oversized packet: truncated at capacity.
    pkt(2, CAP + 2, KW);
    idle(4);

    // Reset in the middle of a capture: outputs clear at once, no done for it.
    step(4'b1000, 4'b1000, 4'b0000, 8);
    step(4'b1000, 4'b1000, 4'b0000, 8);
    rst_n = 1'b0;
    model_reset();
    sif.snoop_TVALID = '0;
    #1 check_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt(3, 3, 2);
    idle(4);

    // Disabled channel is ignored and never counted.
    en = 4'b1110;
    pkt(0, 3, 7);
    idle(4);
    check_drop("t6");
    en = '1;

    // Randomized traffic.
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(63, 0) == 0) en = N'($urandom);
      if (m_cap < 0 && cyc >= m_avail && $urandom_range(9, 0) == 0)
        mr = ($urandom_range(3, 0) != 0);
      step(N'($urandom), N'($urandom | $urandom), N'($urandom & $urandom), 0);
    end
    en = '1;
    mr = 1'b1;
    idle(20);
    check_drop("random");
    check("wr_queue_left", 64'(wq.size()), 64'd0);
    check("done_queue_left", 64'(dq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
